// File: rtl/fsqrt_sched_pkg.sv
// Shared FPU definitions for the fsqrt scheduler: default latency, requester
// tags and the integer square-root kernel used by the datapath.
package fsqrt_sched_pkg;

  localparam int unsigned FSQRT_LAT = 2;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  // Restoring square root: one result bit per radicand bit pair, MSB first.
  function automatic logic [24:0] isqrt50(input logic [49:0] rad);
    logic [26:0] rem;
    logic [26:0] trial;
    logic [24:0] root;
    rem  = '0;
    root = '0;
    for (int i = 24; i >= 0; i--) begin
      rem   = {rem[24:0], rad[2*i +: 2]};
      trial = {root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[23:0], 1'b1};
      end else begin
        root = {root[23:0], 1'b0};
      end
    end
    return root;
  endfunction

endpackage

// File: rtl/fsqrt_sched_fsqrt.sv
// Single-precision square root: combinational core followed by STAGES
// output registers. Denormal inputs are flushed to a signed zero.
module fsqrt_sched_fsqrt
  import fsqrt_sched_pkg::*;
#(
  parameter int unsigned STAGES = FSQRT_LAT - 1
) (
  input  logic        clk,
  input  logic [31:0] x,
  output logic [31:0] y
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        sign;
  logic [7:0]  exp_f;
  logic [22:0] frac;
  logic [49:0] rad;
  logic [24:0] root;
  logic [7:0]  exp_h;
  logic [30:0] mag;
  logic [31:0] y_c;

  assign sign  = x[31];
  assign exp_f = x[30:23];
  assign frac  = x[22:0];

  // An odd unbiased exponent (even biased) moves one factor of two into the radicand.
  assign rad   = exp_f[0] ? {2'b01, frac, 25'd0} : {1'b1, frac, 26'd0};
  assign root  = isqrt50(rad);
  assign exp_h = 8'((9'(exp_f) + 9'd127) >> 1);

  // root[24] is the hidden one, so it lands in the exponent field; root[0] rounds.
  assign mag = {exp_h - 8'd1, 23'd0} + 31'(root[24:1]) + 31'(root[0]);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the branches can leave it unassigned and infer a latch.
  always_comb begin
    y_c = {1'b0, mag};
    if (exp_f == 8'd0) begin
      y_c = {sign, 31'd0};
    end else if (exp_f == 8'hFF) begin
      y_c = (frac != 23'd0 || sign) ? QNAN : 32'h7F80_0000;
    end else if (sign) begin
      y_c = QNAN;
    end
  end

  if (STAGES == 0) begin : g_comb
    assign y = y_c;
  end else begin : g_pipe
    logic [31:0] pipe_q [STAGES];

    // NOTE: pure datapath registers carry no reset; the tag pipe alongside
    // decides validity, so stale values here are never observed.
    always_ff @(posedge clk) begin
      pipe_q[0] <= y_c;
      for (int i = 1; i < int'(STAGES); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign y = pipe_q[STAGES-1];
  end

endmodule

// File: rtl/fsqrt_sched.sv
// Two-requester round-robin front end for a shared pipelined fsqrt, with a
// tag pipe that steers each result back to the port that issued it.
module fsqrt_sched
  import fsqrt_sched_pkg::*;
#(
  parameter int unsigned LAT  = FSQRT_LAT,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [31:0]     req0_x,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [31:0]     req1_x,
  output logic            req1_ready,
  output logic            res0_valid,
  output logic [31:0]     res0_y,
  output logic            res1_valid,
  output logic [31:0]     res1_y,
  output logic            busy,
  output logic [CNTW-1:0] issue_cnt
);

  localparam int unsigned IFW = $clog2(LAT + 2);

  req_id_t         prio_q, prio_d;
  req_id_t         gnt_id;
  logic            xfer;
  logic [1:0]      issue_v;
  logic [31:0]     x_q, x_d;
  logic [31:0]     y;
  tag_t [LAT-1:0]  tag_q, tag_d;
  logic [1:0]      res_valid_q, res_valid_d;
  logic [31:0]     res_y_q [2];
  logic [31:0]     res_y_d [2];
  logic [IFW-1:0]  inflight_q [2];
  logic [IFW-1:0]  inflight_d [2];
  logic [CNTW-1:0] cnt_q, cnt_d;

  // prio_q names the requester that wins when both are valid.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || prio_q == 1'b0)) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  assign issue_v = {req1_ready, req0_ready};
  assign xfer    = |issue_v;
  assign gnt_id  = req1_ready;

  always_comb begin
    prio_d      = prio_q;
    x_d         = x_q;
    cnt_d       = cnt_q;
    res_valid_d = '0;
    tag_d[0]    = '{valid: xfer, id: gnt_id};
    for (int i = 1; i < int'(LAT); i++) begin
      tag_d[i] = tag_q[i-1];
    end
    if (xfer) begin
      prio_d = ~gnt_id;
      x_d    = gnt_id ? req1_x : req0_x;
      cnt_d  = cnt_q + CNTW'(1);
    end
    for (int p = 0; p < 2; p++) begin
      res_valid_d[p] = tag_q[LAT-1].valid && (tag_q[LAT-1].id == req_id_t'(p));
      res_y_d[p]     = res_valid_d[p] ? y : res_y_q[p];
      inflight_d[p]  = inflight_q[p];
      if (issue_v[p] && !res_valid_d[p]) begin
        inflight_d[p] = inflight_q[p] + IFW'(1);
      end else if (!issue_v[p] && res_valid_d[p]) begin
        inflight_d[p] = inflight_q[p] - IFW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= 1'b0;
      x_q         <= '0;
      tag_q       <= '0;
      res_valid_q <= '0;
      cnt_q       <= '0;
      for (int p = 0; p < 2; p++) begin
        res_y_q[p]    <= '0;
        inflight_q[p] <= '0;
      end
    end else begin
      prio_q      <= prio_d;
      x_q         <= x_d;
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
      for (int p = 0; p < 2; p++) begin
        res_y_q[p]    <= res_y_d[p];
        inflight_q[p] <= inflight_d[p];
      end
    end
  end

  fsqrt_sched_fsqrt #(
    .STAGES(LAT - 1)
  ) u_fsqrt (
    .clk(clk),
    .x  (x_q),
    .y  (y)
  );

  assign res0_valid = res_valid_q[0];
  assign res1_valid = res_valid_q[1];
  assign res0_y     = res_y_q[0];
  assign res1_y     = res_y_q[1];
  assign busy       = (inflight_q[0] != '0) || (inflight_q[1] != '0);
  assign issue_cnt  = cnt_q;

endmodule

// File: doc/fsqrt_sched.md
FSQRT_SCHED -- requirements
Module: fsqrt_sched

Interface
REQ-001 The block SHALL have parameter LAT, default 2, giving the fsqrt pipeline depth in cycles from x sampled to y valid.
REQ-002 The block SHALL have parameter CNTW, default 16, giving the width of the issue counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester i presents an operand.
REQ-006 The block SHALL have ports req0_x / req1_x, input, 32 bits each: IEEE-754 single operand.
REQ-007 The block SHALL have ports req0_ready / req1_ready, output, 1 bit each: the grant; a transfer occurs when valid and ready are both 1 at a rising edge.
REQ-008 The block SHALL have ports res0_valid / res1_valid, output, 1 bit each: a one-cycle result pulse.
REQ-009 The block SHALL have ports res0_y / res1_y, output, 32 bits each: the square-root result.
REQ-010 The block SHALL have port busy, output, 1 bit: at least one operation is in flight.
REQ-011 The block SHALL have port issue_cnt, output, CNTW bits: total accepted operations, wrapping.

Function
REQ-012 The block SHALL arbitrate round-robin and grant at most one requester per cycle.
REQ-013 When only one requester has valid=1, that requester SHALL be granted.
REQ-014 When both requesters have valid=1, the requester not granted last SHALL be granted.
REQ-015 After reset, requester 0 SHALL win the first contention.
REQ-016 reqN_ready SHALL be combinational from valid and the priority pointer.
REQ-017 reqN_ready SHALL NOT depend on reqN_x.
REQ-018 reqN_ready SHALL be 0 when reqN_valid is 0.
REQ-019 On a transfer, the granted operand SHALL be registered into the issue register x_q, which drives the fsqrt x input.
REQ-020 On a transfer, the tag pair {valid=1, id} SHALL enter stage 0 of a LAT-deep tag shift register.
REQ-021 In cycles without a transfer, x_q SHALL hold its value and a bubble (valid=0) SHALL enter the tag shift register.
REQ-022 The fsqrt y output SHALL be steered to resN_y of the port whose id is in the last tag stage.
REQ-023 resN_valid SHALL be 1 exactly when the last tag stage is valid and its id is N.
REQ-024 The other port's resN_valid SHALL be 0 in that cycle.
REQ-025 The latency from the handshake edge to resN_valid=1 SHALL be exactly LAT+1 cycles.
REQ-026 Throughput SHALL be one operation per cycle, and results SHALL return in issue order.
REQ-027 Results SHALL have no backpressure; requesters SHALL consume a result in its valid cycle.
REQ-028 resN_y SHALL hold its last value when resN_valid=0.
REQ-029 The block SHALL keep per-port in-flight counters of width clog2(LAT+2).
REQ-030 A port's in-flight counter SHALL increment on that port's issue.
REQ-031 A port's in-flight counter SHALL decrement on that port's result.
REQ-032 A port's in-flight counter SHALL be unchanged when issue and result for that port occur in the same cycle.
REQ-033 busy SHALL be the OR of the in-flight counters being non-zero.
REQ-034 issue_cnt SHALL increment by 1 per transfer and wrap from 2^CNTW-1 to 0.
REQ-035 A requester dropping valid without a transfer SHALL cause no state change.

Reset
REQ-036 While rst=1 at a clock edge, every tag stage SHALL clear to invalid.
REQ-037 While rst=1 at a clock edge, x_q, both resN_y, the in-flight counters and issue_cnt SHALL clear to 0.
REQ-038 While rst=1 at a clock edge, the priority pointer SHALL be set to favour requester 0.
REQ-039 While rst=1, reqN_ready SHALL be 0.
REQ-040 Operations in flight when reset is asserted SHALL be discarded, with no resN_valid pulse after reset.
REQ-041 In the cycle after rst deasserts, the outputs SHALL be resN_valid=0, busy=0 and issue_cnt=0.

Structure
REQ-042 The shared FPU package SHALL hold the default LAT, the requester-id typedef (1 bit) and the tag-stage struct {valid, id}.
REQ-043 The block SHALL instantiate exactly one sub-module, the existing fsqrt datapath, with ports clk, x and y.
REQ-044 The block SHALL contain the arbiter, tag pipe, counters and result steering.

Verification
REQ-045 Reset then a single request: req0 with x=0x40800000 (4.0) SHALL give res0_valid 3 cycles after the handshake, res0_y=0x40000000, busy=0 afterwards, and issue_cnt=1.
REQ-046 Contention: req0 and req1 held valid for 4 cycles, with x0=0x40400000 and x1=0x437F0000, SHALL be granted in the order 0,1,0,1; results SHALL return in that order; res0_y SHALL be within 1 ulp of 0x3FDDB3D7 and res1_y within 1 ulp of 0x417F7FE0.
REQ-047 Back-to-back from one port: req1 issuing 0x00000000 then 0x40000000 on consecutive cycles SHALL produce res1_valid on consecutive cycles with res1_y=0x00000000 then within 1 ulp of 0x3FB504F3; req0_ready SHALL be 0 throughout.
REQ-048 Reset mid-flight: asserting rst for 1 cycle, 1 cycle after issuing 4.0 on req0, SHALL give no res0_valid, busy=0 and issue_cnt=0.
REQ-049 Wrap and bubbles: with CNTW=4, 17 issues separated by idle gaps SHALL leave issue_cnt=1 and produce one result pulse per issue.
